axi_w_upsize_packer: RTL

// W-channel datapath stage of the narrow-to-wide upsizer. It packs narrow slave-side
// W beats into wide master-side W beats: lane placement, strobe merging and

---
 rtl/axi_w_upsize_packer.sv | 224 ++++++++++++++++++++++
 1 files changed

// File: rtl/axi_w_upsize_packer.sv
// axi_w_upsize_packer
//   Packs narrow slave-side W beats into wide master-side W beats for a
//   narrow-to-wide AXI upsizer. Per-burst commands (start offset, size, length,
//   burst type) arrive from the AW path and are queued in a small FIFO.
//
// Ports
//   clk_i, rst_i                      clock / asynchronous active-high reset
//   cmd_valid_i/cmd_ready_o           burst command handshake
//   cmd_offset_i                      start byte offset inside the wide word
//   cmd_size_i, cmd_len_i, cmd_incr_i narrow AXI size, beats-1, INCR(1)/FIXED(0)
//   slv_w_*                           narrow W channel (input side)
//   mst_w_*                           wide W channel (output side, registered)
module axi_w_upsize_packer #(
    parameter int unsigned SI_DATA_WIDTH = 32,
    parameter int unsigned MI_DATA_WIDTH = 64,
    parameter int unsigned USER_WIDTH    = 1,
    parameter int unsigned CMD_DEPTH     = 4
) (
    input  logic                                 clk_i,
    input  logic                                 rst_i,
    input  logic                                 cmd_valid_i,
    output logic                                 cmd_ready_o,
    input  logic [$clog2(MI_DATA_WIDTH/8)-1:0]   cmd_offset_i,
    input  logic [2:0]                           cmd_size_i,
    input  logic [7:0]                           cmd_len_i,
    input  logic                                 cmd_incr_i,
    input  logic [SI_DATA_WIDTH-1:0]             slv_w_data,
    input  logic [SI_DATA_WIDTH/8-1:0]           slv_w_strb,
    input  logic [USER_WIDTH-1:0]                slv_w_user,
    input  logic                                 slv_w_last,
    input  logic                                 slv_w_valid,
    output logic                                 slv_w_ready,
    output logic [MI_DATA_WIDTH-1:0]             mst_w_data,
    output logic [MI_DATA_WIDTH/8-1:0]           mst_w_strb,
    output logic [USER_WIDTH-1:0]                mst_w_user,
    output logic                                 mst_w_last,
    output logic                                 mst_w_valid,
    input  logic                                 mst_w_ready
);
    localparam int unsigned SI_BYTES = SI_DATA_WIDTH / 8;
    localparam int unsigned MI_BYTES = MI_DATA_WIDTH / 8;
    localparam int unsigned OB       = $clog2(MI_BYTES);
    localparam int unsigned LB       = $clog2(SI_BYTES);
    localparam int unsigned LW       = OB - LB;
    localparam int unsigned PW       = $clog2(CMD_DEPTH);
    localparam int unsigned CW       = OB + 3 + 8 + 1;

    if ((MI_DATA_WIDTH % SI_DATA_WIDTH) != 0 || MI_DATA_WIDTH < 2 * SI_DATA_WIDTH) begin : g_bad_ratio
        $error("axi_w_upsize_packer: MI_DATA_WIDTH must be a multiple >= 2 of SI_DATA_WIDTH");
    end

    typedef enum logic {IDLE, ACTIVE} state_e;

    // Command FIFO
    logic [CW-1:0] fifo_mem_q [CMD_DEPTH];
    logic [PW:0]   wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic          fifo_empty, fifo_full, push, pop;
    logic [OB-1:0] head_offset;
    logic [2:0]    head_size;
    logic [7:0]    head_len;
    logic          head_incr;

    assign fifo_empty  = (wr_ptr_q == rd_ptr_q);
    assign fifo_full   = (wr_ptr_q[PW] != rd_ptr_q[PW]) && (wr_ptr_q[PW-1:0] == rd_ptr_q[PW-1:0]);
    assign cmd_ready_o = !rst_i && !fifo_full;
    assign push        = cmd_valid_i && cmd_ready_o;
    assign {head_offset, head_size, head_len, head_incr} = fifo_mem_q[rd_ptr_q[PW-1:0]];

    always_ff @(posedge clk_i) begin
        if (push) begin
            fifo_mem_q[wr_ptr_q[PW-1:0]] <= {cmd_offset_i, cmd_size_i, cmd_len_i, cmd_incr_i};
        end
    end

    // Burst state, accumulator and output register
    state_e                   state_q, state_d;
    logic [OB-1:0]            addr_q, addr_d;
    logic [7:0]               cnt_q, cnt_d;
    logic [2:0]               size_q, size_d;
    logic                     incr_q, incr_d;
    logic [MI_DATA_WIDTH-1:0] acc_data_q, acc_data_d;
    logic [MI_BYTES-1:0]      acc_strb_q, acc_strb_d;
    logic [MI_DATA_WIDTH-1:0] out_data_q, out_data_d;
    logic [MI_BYTES-1:0]      out_strb_q, out_strb_d;
    logic [USER_WIDTH-1:0]    out_user_q, out_user_d;
    logic                     out_last_q, out_last_d;
    logic                     out_valid_q, out_valid_d;

    logic [OB-1:0]            step, addr_next;
    logic [LW-1:0]            lane;
    logic                     beat_completes, beat_fire, load;
    logic [MI_DATA_WIDTH-1:0] merged_data;
    logic [MI_BYTES-1:0]      merged_strb;

    assign mst_w_data  = out_data_q;
    assign mst_w_strb  = out_strb_q;
    assign mst_w_user  = out_user_q;
    assign mst_w_last  = out_last_q;
    assign mst_w_valid = out_valid_q;

    always_comb begin
        step           = OB'(1) << size_q;
        addr_next      = (addr_q & ~(step - OB'(1))) + step;
        lane           = addr_q[OB-1:LB];
        beat_completes = !incr_q || (cnt_q == '0) || (addr_next == '0);
    end

    assign slv_w_ready = (state_q == ACTIVE) && (!beat_completes || !out_valid_q || mst_w_ready);
    assign beat_fire   = slv_w_valid && slv_w_ready;

    // Data is merged per byte under strobe so several sub-lane beats (size < SI)
    // landing in the same lane do not clobber each other's bytes.
    always_comb begin
        merged_data = acc_data_q;
        merged_strb = acc_strb_q;
        for (int unsigned j = 0; j < MI_BYTES; j++) begin
            if (LW'(j / SI_BYTES) == lane && slv_w_strb[j % SI_BYTES]) begin
                merged_data[j*8 +: 8] = slv_w_data[(j % SI_BYTES)*8 +: 8];
                merged_strb[j]        = 1'b1;
            end
        end
    end

    always_comb begin
        state_d     = state_q;
        addr_d      = addr_q;
        cnt_d       = cnt_q;
        size_d      = size_q;
        incr_d      = incr_q;
        acc_data_d  = acc_data_q;
        acc_strb_d  = acc_strb_q;
        out_data_d  = out_data_q;
        out_strb_d  = out_strb_q;
        out_user_d  = out_user_q;
        out_last_d  = out_last_q;
        out_valid_d = out_valid_q && !mst_w_ready;
        load        = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (!fifo_empty) begin
                    load    = 1'b1;
                    state_d = ACTIVE;
                end
            end
            ACTIVE: begin
                if (beat_fire) begin
                    cnt_d = cnt_q - 8'd1;
                    if (incr_q) begin
                        addr_d = addr_next;
                    end
                    if (beat_completes) begin
                        out_data_d  = merged_data;
                        out_strb_d  = merged_strb;
                        out_user_d  = slv_w_user;
                        out_last_d  = (cnt_q == '0);
                        out_valid_d = 1'b1;
                        acc_data_d  = '0;
                        acc_strb_d  = '0;
                    end else begin
                        acc_data_d  = merged_data;
                        acc_strb_d  = merged_strb;
                    end
                    // Chain straight into the next queued burst to avoid a bubble.
                    if (cnt_q == '0) begin
                        if (!fifo_empty) begin
                            load = 1'b1;
                        end else begin
                            state_d = IDLE;
                        end
                    end
                end
            end
            default: state_d = IDLE;
        endcase
        if (load) begin
            addr_d = head_offset;
            cnt_d  = head_len;
            size_d = head_size;
            incr_d = head_incr;
        end
        pop      = load;
        wr_ptr_d = wr_ptr_q + {{PW{1'b0}}, push};
        rd_ptr_d = rd_ptr_q + {{PW{1'b0}}, pop};
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q     <= IDLE;
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            addr_q      <= '0;
            cnt_q       <= '0;
            size_q      <= '0;
            incr_q      <= 1'b0;
            acc_data_q  <= '0;
            acc_strb_q  <= '0;
            out_data_q  <= '0;
            out_strb_q  <= '0;
            out_user_q  <= '0;
            out_last_q  <= 1'b0;
            out_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            addr_q      <= addr_d;
            cnt_q       <= cnt_d;
            size_q      <= size_d;
            incr_q      <= incr_d;
            acc_data_q  <= acc_data_d;
            acc_strb_q  <= acc_strb_d;
            out_data_q  <= out_data_d;
            out_strb_q  <= out_strb_d;
            out_user_q  <= out_user_d;
            out_last_q  <= out_last_d;
            out_valid_q <= out_valid_d;
        end
    end

    a_slv_last_matches_cnt: assert property (@(posedge clk_i) disable iff (rst_i)
        beat_fire |-> (slv_w_last == (cnt_q == '0)));
    a_cmd_size_legal: assert property (@(posedge clk_i) disable iff (rst_i)
        push |-> (cmd_size_i <= 3'(LB)));
endmodule
